// File: rtl/mvm_host_driver.sv
// Host-side sequencer for the mvm engine: buffers the N*N+N operands, drives the start/data_in
// protocol, captures the result burst and returns it downstream on a valid/ready stream.
module mvm_host_driver #(
  parameter int MAT_SCALE    = 4,
  parameter int INPUT_WIDTH  = 8,
  parameter int OUTPUT_WIDTH = 16,
  parameter int RESULT_LAG   = 1,
  parameter int TIMEOUT      = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [INPUT_WIDTH-1:0]  in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OUTPUT_WIDTH-1:0] out_data,
  output logic                    out_last,
  output logic                    mvm_start,
  output logic [INPUT_WIDTH-1:0]  mvm_data,
  input  logic                    mvm_done,
  input  logic [OUTPUT_WIDTH-1:0] mvm_result,
  output logic                    busy,
  output logic                    error
);

  localparam int N_OPS  = MAT_SCALE * MAT_SCALE + MAT_SCALE;
  localparam int CNT_W  = $clog2(N_OPS + 1);
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam int LAG_W  = $clog2(RESULT_LAG + 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LOAD      = 3'd1;
  localparam logic [2:0] S_START     = 3'd2;
  localparam logic [2:0] S_STREAM    = 3'd3;
  localparam logic [2:0] S_WAIT_DONE = 3'd4;
  localparam logic [2:0] S_CAPTURE   = 3'd5;
  localparam logic [2:0] S_DRAIN     = 3'd6;

  logic [2:0]              r_state;
  logic [CNT_W-1:0]        r_op_cnt;
  logic [CNT_W-1:0]        r_res_cnt;
  logic [CNT_W-1:0]        r_rd_cnt;
  logic [WAIT_W-1:0]       r_wait_cnt;
  logic [LAG_W-1:0]        r_lag;
  logic [INPUT_WIDTH-1:0]  r_op_buf  [N_OPS];
  logic [OUTPUT_WIDTH-1:0] r_res_buf [MAT_SCALE];
  logic                    r_in_ready;
  logic                    r_out_valid;
  logic                    r_mvm_start;
  logic [INPUT_WIDTH-1:0]  r_mvm_data;
  logic                    r_error;

  logic                    w_accept;
  logic                    w_op_last;
  logic                    w_res_last;
  logic                    w_rd_last;
  logic [CNT_W-1:0]        w_op_nxt;

  assign w_accept   = in_valid & r_in_ready;
  assign w_op_last  = (r_op_cnt == CNT_W'(N_OPS - 1));
  assign w_res_last = (r_res_cnt == CNT_W'(MAT_SCALE - 1));
  assign w_rd_last  = (r_rd_cnt == CNT_W'(MAT_SCALE - 1));
  assign w_op_nxt   = r_op_cnt + CNT_W'(1);

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_valid ? r_res_buf[r_rd_cnt] : '0;
  assign out_last  = r_out_valid & w_rd_last;
  assign mvm_start = r_mvm_start;
  assign mvm_data  = r_mvm_data;
  assign busy      = (r_state != S_IDLE);
  assign error     = r_error;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_op_cnt    <= '0;
      r_res_cnt   <= '0;
      r_rd_cnt    <= '0;
      r_wait_cnt  <= '0;
      r_lag       <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_mvm_start <= 1'b0;
      r_mvm_data  <= '0;
      r_error     <= 1'b0;
      for (int i = 0; i < N_OPS; i++) r_op_buf[i] <= '0;
      for (int i = 0; i < MAT_SCALE; i++) r_res_buf[i] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_in_ready <= 1'b1;
          r_state    <= S_LOAD;
        end
        S_LOAD: begin
          if (w_accept) begin
            r_op_buf[r_op_cnt] <= in_data;
            r_op_cnt           <= w_op_nxt;
            if (w_op_last) begin
              r_in_ready  <= 1'b0;
              r_mvm_start <= 1'b1;
              r_mvm_data  <= r_op_buf[0];
              r_state     <= S_START;
            end
          end
        end
        S_START: begin
          r_mvm_start <= 1'b0;
          r_mvm_data  <= r_op_buf[0];
          r_op_cnt    <= '0;
          r_state     <= S_STREAM;
        end
        // mvm_data always shows op_buf[r_op_cnt]; the next word is fetched one cycle ahead.
        S_STREAM: begin
          if (w_op_last) begin
            r_op_cnt   <= '0;
            r_wait_cnt <= '0;
            r_state    <= S_WAIT_DONE;
          end else begin
            r_mvm_data <= r_op_buf[w_op_nxt];
            r_op_cnt   <= w_op_nxt;
          end
        end
        S_WAIT_DONE: begin
          if (mvm_done) begin
            r_wait_cnt <= '0;
            r_lag      <= LAG_W'(RESULT_LAG - 1);
            r_res_cnt  <= '0;
            r_state    <= S_CAPTURE;
          end else if (r_wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
            r_wait_cnt <= '0;
            r_error    <= 1'b1;
            r_state    <= S_IDLE;
          end else begin
            r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
          end
        end
        S_CAPTURE: begin
          if (r_lag != '0) begin
            r_lag <= r_lag - LAG_W'(1);
          end else begin
            r_res_buf[r_res_cnt] <= mvm_result;
            if (w_res_last) begin
              r_res_cnt   <= '0;
              r_rd_cnt    <= '0;
              r_out_valid <= 1'b1;
              r_state     <= S_DRAIN;
            end else begin
              r_res_cnt <= r_res_cnt + CNT_W'(1);
            end
          end
        end
        S_DRAIN: begin
          if (out_ready) begin
            if (w_rd_last) begin
              r_out_valid <= 1'b0;
              r_rd_cnt    <= '0;
              r_state     <= S_IDLE;
            end else begin
              r_rd_cnt <= r_rd_cnt + CNT_W'(1);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mvm_host_driver.md
Name: mvm_host_driver

Overview:
- Host-side sequencer for the 4x4 matrix-vector multiplier (mvm) engine.
- Accepts the matrix and vector operands from an upstream valid/ready stream and buffers them.
- Drives the engine's start/data_in protocol, then captures the engine's unflow-controlled result burst.
- Returns the results downstream on a valid/ready stream with a last marker.

Parameters:
- MAT_SCALE, 4, matrix dimension N; operand count = N*N+N, result count = N.
- INPUT_WIDTH, 8, signed operand width.
- OUTPUT_WIDTH, 16, signed result width.
- RESULT_LAG, 1, cycles from the cycle mvm_done is sampled high to the cycle result 0 is sampled.
- TIMEOUT, 255, maximum cycles spent in WAIT_DONE before error.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous reset, active-high.
- in_valid  in  1  upstream operand valid.
- in_ready  out  1  upstream operand ready.
- in_data  in  INPUT_WIDTH  operand: A row-major (A[0][0]..A[N-1][N-1]), then x[0]..x[N-1].
- out_valid  out  1  result valid.
- out_ready  in  1  downstream ready.
- out_data  out  OUTPUT_WIDTH  result y[i].
- out_last  out  1  high with y[N-1].
- mvm_start  out  1  one-cycle start pulse to the engine.
- mvm_data  out  INPUT_WIDTH  operand stream to the engine's data_in.
- mvm_done  in  1  engine done pulse.
- mvm_result  in  OUTPUT_WIDTH  engine data_out.
- busy  out  1  high in every state except IDLE.
- error  out  1  sticky timeout flag, cleared only by reset.

Behaviour:
- Reset values: in_ready=0, out_valid=0, out_last=0, out_data=0, mvm_start=0, mvm_data=0, busy=0, error=0, all counters=0, state=IDLE.
- Reset mid-operation aborts immediately. Buffered operands and results are discarded, and no mvm_start is issued after reset.
- States: IDLE, LOAD, START, STREAM, WAIT_DONE, CAPTURE, DRAIN.
- IDLE: go to LOAD on the next cycle. in_ready is registered and goes high on entry to LOAD.
- LOAD:
  - A word is accepted when in_valid & in_ready, stored at op_buf[op_cnt], and op_cnt increments.
  - On acceptance of word N*N+N-1: in_ready=0 in the next cycle, go to START.
  - Stalls (in_valid=0) are allowed at any point.
- START: mvm_start=1 for exactly one cycle, mvm_data=op_buf[0], op_cnt cleared; go to STREAM.
- STREAM:
  - In cycle k after the start cycle (k=1..N*N+N), mvm_data=op_buf[k-1], strictly back-to-back with no gaps.
  - The engine requires element 0 in the cycle after start, so the buffer read is registered one cycle ahead.
  - After the last element, go to WAIT_DONE. mvm_data holds its last value.
- WAIT_DONE:
  - A cycle counter increments each cycle.
  - mvm_done=1: go to CAPTURE.
  - Counter reaches TIMEOUT without done: set error=1 and return to IDLE.
  - mvm_done high in any other state is ignored.
- CAPTURE:
  - Wait RESULT_LAG-1 cycles after leaving WAIT_DONE.
  - Then sample mvm_result into res_buf[0..N-1] on N consecutive cycles; go to DRAIN.
- DRAIN:
  - out_valid=1, out_data=res_buf[rd_cnt], out_last=(rd_cnt==N-1).
  - Advance on out_valid & out_ready. out_data and out_last hold stable while out_ready=0.
  - After the handshake with out_last=1: out_valid=0 next cycle, go to IDLE.
- Widths: counters are clog2(N*N+N+1) bits. Values are passed through unmodified with no sign extension or truncation; results are stored at full OUTPUT_WIDTH.
- No upstream acceptance occurs outside LOAD; in_ready=0 in all other states.
- Throughput per job: (N*N+N) load cycles minimum, +1 start, +N*N+N stream, engine latency, RESULT_LAG+N capture, then N or more drain cycles.

Test Plan:
- Basic job:
  - Stimulus: N=4, A all 1, x=1,2,3,4, in_valid always high, out_ready always high.
  - Required: mvm_start pulses exactly once, the 20 elements appear on mvm_data on the 20 cycles after start, outputs are 10,10,10,10, and out_last is high on the 4th output only.
- Signed identity:
  - Stimulus: A=identity, x=-1,2,-128,127.
  - Required: outputs 0xFFFF, 0x0002, 0xFF80, 0x007F (signed: -1, 2, -128, 127), with sign preserved at 16 bits.
- Upstream stalls:
  - Stimulus: in_valid toggles 1,0,0,1,... during LOAD.
  - Required: all 20 words are captured in order, and the STREAM phase is still gapless with identical mvm_data ordering.
- Downstream backpressure:
  - Stimulus: out_ready low for 5 cycles at y[1].
  - Required: out_data holds y[1] stable with out_valid high, no result is lost, and out_last is high on y[3] only.
- Timeout:
  - Stimulus: mvm_done never asserted.
  - Required: error=1 exactly TIMEOUT cycles after entry to WAIT_DONE, then state IDLE, then in_ready=1 again in LOAD. A later good job completes with error still 1.
- Reset mid-stream:
  - Stimulus: reset asserted at stream element 7.
  - Required: all outputs return to reset values on the next cycle and no further mvm_start is issued. A subsequent full job produces correct results.
